// File: rtl/spi_interface.sv
// spi_interface: transmit-only SPI master (mode 0) that shifts out a DATA_W-bit
// word whenever the parallel input differs from the last word sent.
// Optional build macro: SPI_INTERFACE_LSB_FIRST_EN selects LSB-first bit order
// (default, macro undefined: MSB first).
module spi_interface #(
  parameter int unsigned DATA_W     = 40,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  output logic [7:0]        counter,
  output logic              spi_sclk,
  output logic              spi_data
);

  localparam int unsigned TMR_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       CNT_LAST = 8'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [DATA_W-1:0]  shift_reg, shift_reg_d;
  logic [DATA_W-1:0]  last_word, last_word_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic [7:0]         counter_d;
  logic               spi_sclk_d;
  logic               spi_data_d;

  logic               start;
  logic               half_done;
  logic               fall;
  logic               last_bit;
  logic [7:0]         counter_inc;
  logic               load_bit;
  logic               next_bit;
  logic [DATA_W-1:0]  shift_next;

  assign start       = (data != last_word);
  assign half_done   = (timer == TMR_LAST);
  assign fall        = half_done && spi_sclk;
  assign counter_inc = 8'(counter + 8'd1);
  assign last_bit    = (counter_inc == CNT_LAST);

  // Bit-order selection; the register rotates so no bit is left dangling,
  // and only the first DATA_W bits out of it are ever driven onto spi_data.
`ifdef SPI_INTERFACE_LSB_FIRST_EN
  assign load_bit   = data[0];
  assign next_bit   = shift_reg[1];
  assign shift_next = {shift_reg[0], shift_reg[DATA_W-1:1]};
`else
  assign load_bit   = data[DATA_W-1];
  assign next_bit   = shift_reg[DATA_W-2];
  assign shift_next = {shift_reg[DATA_W-2:0], shift_reg[DATA_W-1]};
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state: start on a new word, finish after the last falling edge, gap then idle.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (fall && last_bit) state_d = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values for every registered signal.
  always_comb begin
    shift_reg_d = shift_reg;
    last_word_d = last_word;
    timer_d     = timer;
    gap_cnt_d   = gap_cnt;
    counter_d   = counter;
    spi_sclk_d  = spi_sclk;
    spi_data_d  = spi_data;
    case (state)
      IDLE: begin
        spi_sclk_d = 1'b0;
        spi_data_d = 1'b0;
        counter_d  = 8'd0;
        timer_d    = '0;
        gap_cnt_d  = '0;
        if (start) begin
          shift_reg_d = data;
          last_word_d = data;
          spi_data_d  = load_bit;
        end
      end
      SHIFT: begin
        if (half_done) begin
          timer_d = '0;
          if (!spi_sclk) begin
            spi_sclk_d = 1'b1;
          end else begin
            spi_sclk_d  = 1'b0;
            counter_d   = counter_inc;
            shift_reg_d = shift_next;
            spi_data_d  = last_bit ? 1'b0 : next_bit;
          end
        end else begin
          timer_d = TMR_W'(timer + 1'b1);
        end
      end
      GAP: begin
        spi_sclk_d = 1'b0;
        spi_data_d = 1'b0;
        counter_d  = CNT_LAST;
        gap_cnt_d  = GAP_W'(gap_cnt + 1'b1);
        if (gap_cnt == GAP_LAST) begin
          counter_d = 8'd0;
          gap_cnt_d = '0;
        end
      end
      default: begin
        spi_sclk_d = 1'b0;
        spi_data_d = 1'b0;
        counter_d  = 8'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      last_word <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      counter   <= 8'd0;
      spi_sclk  <= 1'b0;
      spi_data  <= 1'b0;
    end else begin
      shift_reg <= shift_reg_d;
      last_word <= last_word_d;
      timer     <= timer_d;
      gap_cnt   <= gap_cnt_d;
      counter   <= counter_d;
      spi_sclk  <= spi_sclk_d;
      spi_data  <= spi_data_d;
    end
  end

endmodule

// File: tb/tb_spi_interface.sv
// Directed bench for spi_interface at default parameters.
module tb_spi_interface;

  localparam int unsigned DATA_W     = 40;
  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int unsigned FRAME      = DATA_W * 2 * CLK_DIV;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data;
  logic [7:0]        counter;
  logic              spi_sclk;
  logic              spi_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_interface #(
    .DATA_W    (DATA_W),
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .counter (counter),
    .spi_sclk(spi_sclk),
    .spi_data(spi_data)
  );

  // Serial receiver model: samples spi_data on each rising spi_sclk seen at negedge clk.
  logic              prev_sclk = 1'b0;
  int                rise_cnt  = 0;
  int                edge_cnt  = 0;
  logic [DATA_W-1:0] rx        = '0;

  always @(negedge clk) begin
    if (spi_sclk !== prev_sclk) edge_cnt <= edge_cnt + 1;
    if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
      rise_cnt <= rise_cnt + 1;
`ifdef SPI_INTERFACE_LSB_FIRST_EN
      rx <= {spi_data, rx[DATA_W-1:1]};
`else
      rx <= {rx[DATA_W-2:0], spi_data};
`endif
    end
    prev_sclk <= spi_sclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_counter(input logic [7:0] val, input int budget, output int cycles);
    cycles = 0;
    while (counter !== val && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    check("watchdog", 64'd1, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int base_r;
    int base_e;
    int first_idx;
    logic first_exp;

    // Held reset with a nonzero word: everything stays quiet.
    reset = 1'b0;
    data  = 40'h12_3456_789A;
    repeat (200) tick();
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_data", spi_data, 1'b0);
    check("rst_counter", counter, 8'd0);
    check("rst_edges", edge_cnt, 0);

    // Release with data equal to the cleared last_word: no frame.
    data = '0;
    tick();
    reset = 1'b1;
    base_e = edge_cnt;
    repeat (20) tick();
    check("zero_no_frame", edge_cnt - base_e, 0);

    // Single frame.
    base_r = rise_cnt;
    data   = 40'hA5_0000_00F1;
    wait_counter(8'd40, 400, cyc);
    check("f1_reach", counter, 8'd40);
    check("f1_len", cyc, FRAME + 1);
    check("f1_rises", rise_cnt - base_r, 40);
    check("f1_word", rx, 40'hA5_0000_00F1);
    check("f1_gap_data", spi_data, 1'b0);
    repeat (GAP_CYCLES - 1) tick();
    check("f1_gap_counter", counter, 8'd40);
    tick();
    check("f1_idle_counter", counter, 8'd0);

    // Constant data: no retrigger.
    base_e = edge_cnt;
    repeat (500) tick();
    check("noretrig_edges", edge_cnt - base_e, 0);
    check("noretrig_counter", counter, 8'd0);

    // Mid-frame changes are dropped; the newest value goes next.
    base_r = rise_cnt;
    data   = 40'hFF_00FF_00FF;
    repeat (30) tick();
    data = 40'h1;
    repeat (40) tick();
    data = 40'h2;
    wait_counter(8'd40, 400, cyc);
    check("mid_f1_reach", counter, 8'd40);
    check("mid_f1_rises", rise_cnt - base_r, 40);
    check("mid_f1_word", rx, 40'hFF_00FF_00FF);
    base_r = rise_cnt;
    wait_counter(8'd0, 20, cyc);
    wait_counter(8'd40, 400, cyc);
    check("mid_f2_reach", counter, 8'd40);
    check("mid_f2_rises", rise_cnt - base_r, 40);
    check("mid_f2_word", rx, 40'h2);
    wait_counter(8'd0, 20, cyc);
    base_e = edge_cnt;
    repeat (300) tick();
    check("mid_after_edges", edge_cnt - base_e, 0);

    // Asynchronous reset at bit 17, then a full frame of the same word.
    base_r = rise_cnt;
    data   = 40'h3C_5A5A_0F0F;
    cyc    = 0;
    while ((rise_cnt - base_r) != 17 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("ar_bit17", rise_cnt - base_r, 17);
    check("ar_pre_counter", counter, 8'd16);
    #2;
    reset = 1'b0;
    #1;
    check("ar_sclk", spi_sclk, 1'b0);
    check("ar_data", spi_data, 1'b0);
    check("ar_counter", counter, 8'd0);
    repeat (5) tick();
    reset  = 1'b1;
    base_r = rise_cnt;
    wait_counter(8'd40, 400, cyc);
    check("ar_len", cyc, FRAME + 1);
    check("ar_rises", rise_cnt - base_r, 40);
    check("ar_word", rx, 40'h3C_5A5A_0F0F);
    wait_counter(8'd0, 20, cyc);

    // Bit order with a single set LSB.
`ifdef SPI_INTERFACE_LSB_FIRST_EN
    first_idx = 0;
    first_exp = 1'b1;
`else
    first_idx = DATA_W - 1;
    first_exp = 1'b0;
`endif
    base_r = rise_cnt;
    data   = 40'h1;
    wait_counter(8'd40, 400, cyc);
    check("ord_rises", rise_cnt - base_r, 40);
    check("ord_first_bit", rx[first_idx], first_exp);
    check("ord_word", rx, 40'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
